// File: rtl/c64_io_bus_interface.sv
// -----------------------------------------------------------------------------
// c64_io_bus_interface
//
// Bridges the asynchronous C64 expansion-port I/O1 bus to the strobe interface
// of the on-chip register block. Bus signals are synchronised into the clk
// domain and PHI2 rising edges are detected. Accesses to a 16-byte window are
// decoded and turned into exactly one single-cycle read or write strobe per
// qualifying PHI2 cycle. Read data is driven back onto the bus until PHI2 falls.
//
// Ports
//   clk           core clock (>= 16x PHI2)
//   reset         asynchronous, active-low reset
//   phi2          C64 PHI2 clock (async)
//   io1_n         C64 I/O1 select, active-low (async)
//   rw            C64 R/W, 1 = read (async)
//   bus_a[7:0]    C64 address bus (async)
//   bus_d_in[7:0] C64 data bus as sampled (async)
//   bus_d_out     read data to drive onto the C64 data bus
//   bus_d_oe      data-bus output enable, active-high
//   a[3:0]        register address to the register block
//   d_d[7:0]      write data to the register block
//   d_q[7:0]      read data from the register block
//   read_strobe   single-cycle read request
//   write_strobe  single-cycle write request
//   busy          high while the FSM is not idle
// -----------------------------------------------------------------------------
module c64_io_bus_interface #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [3:0]  WINDOW_HI   = 4'h0,
    parameter int unsigned WRITE_DELAY = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       phi2,
    input  logic       io1_n,
    input  logic       rw,
    input  logic [7:0] bus_a,
    input  logic [7:0] bus_d_in,
    output logic [7:0] bus_d_out,
    output logic       bus_d_oe,
    output logic [3:0] a,
    output logic [7:0] d_d,
    input  logic [7:0] d_q,
    output logic       read_strobe,
    output logic       write_strobe,
    output logic       busy
);

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SYNC_W = 3 + ADDR_W + DATA_W;
    localparam int unsigned CNT_W  = 8;

    // Count value seen in cycle T+WRITE_DELAY (counter is cleared for T+1).
    localparam logic [CNT_W-1:0] CAPTURE_AT = CNT_W'(WRITE_DELAY - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RD_STROBE = 3'd1;
    localparam logic [2:0] RD_WAIT   = 3'd2;
    localparam logic [2:0] RD_DRIVE  = 3'd3;
    localparam logic [2:0] WR_WAIT   = 3'd4;
    localparam logic [2:0] WR_STROBE = 3'd5;
    localparam logic [2:0] HOLD      = 3'd6;

    // Reject illegal parameterisations at elaboration.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("c64_io_bus_interface: SYNC_STAGES must be 2 or 3");
    end
    if (WRITE_DELAY < 1 || WRITE_DELAY > 255) begin : g_bad_delay
        $error("c64_io_bus_interface: WRITE_DELAY must be in 1..255");
    end

    // -------------------------------------------------------------------------
    // Input synchronisers: all async bus inputs share one shift chain.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][SYNC_W-1:0] sync_q;
    logic [SYNC_W-1:0]                  sync_in;
    logic [SYNC_W-1:0]                  sync_out;

    assign sync_in  = {phi2, io1_n, rw, bus_a, bus_d_in};
    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sync_in};
        end
    end

    logic              phi2_s;
    logic              io1_n_s;
    logic              rw_s;
    logic [ADDR_W-1:0] bus_a_s;
    logic [DATA_W-1:0] bus_d_s;

    assign phi2_s  = sync_out[SYNC_W-1];
    assign io1_n_s = sync_out[SYNC_W-2];
    assign rw_s    = sync_out[SYNC_W-3];
    assign bus_a_s = sync_out[ADDR_W+DATA_W-1:DATA_W];
    assign bus_d_s = sync_out[DATA_W-1:0];

    // -------------------------------------------------------------------------
    // PHI2 rise detection on the synchronised copy.
    // -------------------------------------------------------------------------
    logic phi2_prev;
    logic phi2_rise_c;
    logic hit_c;

    assign phi2_rise_c = phi2_s && !phi2_prev;
    assign hit_c       = phi2_rise_c && !io1_n_s && (bus_a_s[7:4] == WINDOW_HI);

    // -------------------------------------------------------------------------
    // State and output registers.
    // -------------------------------------------------------------------------
    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [3:0]        a_nxt;
    logic [DATA_W-1:0] d_d_nxt;
    logic [DATA_W-1:0] bus_d_out_nxt;
    logic              bus_d_oe_nxt;
    logic              read_strobe_nxt;
    logic              write_strobe_nxt;
    logic              busy_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            phi2_prev    <= 1'b0;
            cnt          <= '0;
            a            <= '0;
            d_d          <= '0;
            bus_d_out    <= '0;
            bus_d_oe     <= 1'b0;
            read_strobe  <= 1'b0;
            write_strobe <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            phi2_prev    <= phi2_s;
            cnt          <= cnt_nxt;
            a            <= a_nxt;
            d_d          <= d_d_nxt;
            bus_d_out    <= bus_d_out_nxt;
            bus_d_oe     <= bus_d_oe_nxt;
            read_strobe  <= read_strobe_nxt;
            write_strobe <= write_strobe_nxt;
            busy         <= busy_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic. Strobes, oe and busy are decoded from
    // the next state so their registered copies line up with the state itself.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        a_nxt         = a;
        d_d_nxt       = d_d;
        bus_d_out_nxt = bus_d_out;

        case (state)
            IDLE: begin
                // Only IDLE accepts a new PHI2 rise; direction and address are
                // frozen here and later bus activity cannot change them.
                if (hit_c) begin
                    a_nxt = bus_a_s[3:0];
                    if (rw_s) begin
                        state_nxt = RD_STROBE;
                    end else begin
                        state_nxt = WR_WAIT;
                        cnt_nxt   = '0;
                    end
                end
            end
            RD_STROBE: begin
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                bus_d_out_nxt = d_q;
                state_nxt     = RD_DRIVE;
            end
            RD_DRIVE: begin
                if (!phi2_s) begin
                    state_nxt = IDLE;
                end
            end
            WR_WAIT: begin
                // A PHI2 fall before capture aborts the write without a strobe.
                if (!phi2_s) begin
                    state_nxt = IDLE;
                end else if (cnt == CAPTURE_AT) begin
                    d_d_nxt   = bus_d_s;
                    state_nxt = WR_STROBE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WR_STROBE: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (!phi2_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        read_strobe_nxt  = (state_nxt == RD_STROBE);
        write_strobe_nxt = (state_nxt == WR_STROBE);
        bus_d_oe_nxt     = (state_nxt == RD_DRIVE);
        busy_nxt         = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_c64_io_bus_interface.sv
// -----------------------------------------------------------------------------
// tb_c64_io_bus_interface
//
// Directed self-checking bench for c64_io_bus_interface with default
// parameters (SYNC_STAGES = 2, WINDOW_HI = 0, WRITE_DELAY = 24).
// Inputs change on the falling clk edge; outputs are sampled there as well.
// Sample point k counts falling edges after PHI2 is driven high; with two
// synchroniser stages, detection cycle T lands on k = 2, so T+n is k = n+2.
// -----------------------------------------------------------------------------
module tb_c64_io_bus_interface;

    logic       clk;
    logic       reset;
    logic       phi2;
    logic       io1_n;
    logic       rw;
    logic [7:0] bus_a;
    logic [7:0] bus_d_in;
    logic [7:0] bus_d_out;
    logic       bus_d_oe;
    logic [3:0] a;
    logic [7:0] d_d;
    logic [7:0] d_q;
    logic       read_strobe;
    logic       write_strobe;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Strobe / oe activity monitor.
    int   rd_cnt  = 0;
    int   wr_cnt  = 0;
    int   oe_cnt  = 0;
    int   dbl_cnt = 0;
    logic prev_strobe = 1'b0;

    c64_io_bus_interface dut (
        .clk          (clk),
        .reset        (reset),
        .phi2         (phi2),
        .io1_n        (io1_n),
        .rw           (rw),
        .bus_a        (bus_a),
        .bus_d_in     (bus_d_in),
        .bus_d_out    (bus_d_out),
        .bus_d_oe     (bus_d_oe),
        .a            (a),
        .d_d          (d_d),
        .d_q          (d_q),
        .read_strobe  (read_strobe),
        .write_strobe (write_strobe),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (read_strobe)  rd_cnt <= rd_cnt + 1;
        if (write_strobe) wr_cnt <= wr_cnt + 1;
        if (bus_d_oe)     oe_cnt <= oe_cnt + 1;
        if ((read_strobe && write_strobe) ||
            ((read_strobe || write_strobe) && prev_strobe))
            dbl_cnt <= dbl_cnt + 1;
        prev_strobe <= read_strobe || write_strobe;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_cycle(input logic [7:0] addr, input logic rw_v,
                               input logic [7:0] din, input logic [7:0] dq,
                               input logic io1_v);
        bus_a    = addr;
        rw       = rw_v;
        bus_d_in = din;
        d_q      = dq;
        io1_n    = io1_v;
        phi2     = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_oe"},   bus_d_oe,     1'b0);
        check({tag, "_dout"}, bus_d_out,    8'h00);
        check({tag, "_a"},    a,            4'h0);
        check({tag, "_dd"},   d_d,          8'h00);
        check({tag, "_rs"},   read_strobe,  1'b0);
        check({tag, "_ws"},   write_strobe, 1'b0);
        check({tag, "_busy"}, busy,         1'b0);
    endtask

    int rd0, wr0, oe0;

    initial begin
        reset    = 1'b0;
        phi2     = 1'b0;
        io1_n    = 1'b1;
        rw       = 1'b1;
        bus_a    = 8'h00;
        bus_d_in = 8'h00;
        d_q      = 8'h00;

        // ---- Reset state ----
        wait_neg(3);
        check_all_zero("reset");
        reset = 1'b1;
        wait_neg(5);

        // ---- Read hit: addr 1, d_q 73 ----
        rd0 = rd_cnt; wr0 = wr_cnt;
        start_cycle(8'h01, 1'b1, 8'h00, 8'h73, 1'b0);
        wait_neg(2);                                   // k=2 (T)
        check("rd_T_rs", read_strobe, 1'b0);
        check("rd_T_busy", busy, 1'b0);
        wait_neg(1);                                   // k=3 (T+1)
        check("rd_T1_rs", read_strobe, 1'b1);
        check("rd_T1_a", a, 4'h1);
        check("rd_T1_busy", busy, 1'b1);
        wait_neg(1);                                   // k=4 (T+2)
        check("rd_T2_rs", read_strobe, 1'b0);
        check("rd_T2_oe", bus_d_oe, 1'b0);
        wait_neg(1);                                   // k=5 (T+3)
        check("rd_T3_oe", bus_d_oe, 1'b1);
        check("rd_T3_dout", bus_d_out, 8'h73);
        wait_neg(10);                                  // k=15
        check("rd_hold_oe", bus_d_oe, 1'b1);
        phi2 = 1'b0;
        wait_neg(2);                                   // k=17, synced low seen
        check("rd_fall_oe", bus_d_oe, 1'b1);
        wait_neg(1);                                   // k=18
        check("rd_end_oe", bus_d_oe, 1'b0);
        check("rd_end_busy", busy, 1'b0);
        check("rd_end_dout", bus_d_out, 8'h73);
        #1;
        check("rd_count", rd_cnt - rd0, 1);
        check("rd_no_wr", wr_cnt - wr0, 0);
        io1_n = 1'b1;
        wait_neg(10);

        // ---- Write hit: addr 0, data 52 ----
        rd0 = rd_cnt; wr0 = wr_cnt; oe0 = oe_cnt;
        start_cycle(8'h00, 1'b0, 8'h52, 8'h00, 1'b0);
        wait_neg(3);                                   // k=3 (T+1)
        check("wr_T1_busy", busy, 1'b1);
        check("wr_T1_a", a, 4'h0);
        wait_neg(23);                                  // k=26 (T+24)
        check("wr_T24_ws", write_strobe, 1'b0);
        wait_neg(1);                                   // k=27 (T+25)
        check("wr_T25_ws", write_strobe, 1'b1);
        check("wr_T25_a", a, 4'h0);
        check("wr_T25_dd", d_d, 8'h52);
        wait_neg(1);                                   // k=28
        check("wr_T26_ws", write_strobe, 1'b0);
        check("wr_hold_busy", busy, 1'b1);
        wait_neg(2);                                   // k=30
        phi2 = 1'b0;
        wait_neg(3);                                   // k=33
        check("wr_end_busy", busy, 1'b0);
        #1;
        check("wr_count", wr_cnt - wr0, 1);
        check("wr_no_rd", rd_cnt - rd0, 0);
        check("wr_no_oe", oe_cnt - oe0, 0);
        io1_n = 1'b1;
        wait_neg(10);

        // ---- Write abort: PHI2 high for 10 clk ----
        wr0 = wr_cnt; oe0 = oe_cnt;
        start_cycle(8'h03, 1'b0, 8'hAA, 8'h00, 1'b0);
        wait_neg(10);                                  // k=10
        phi2 = 1'b0;
        wait_neg(1);                                   // k=11
        check("ab_busy_hi", busy, 1'b1);
        wait_neg(2);                                   // k=13
        check("ab_busy_lo", busy, 1'b0);
        check("ab_dd", d_d, 8'h52);
        wait_neg(30);
        #1;
        check("ab_no_wr", wr_cnt - wr0, 0);
        check("ab_no_oe", oe_cnt - oe0, 0);
        check("ab_dd_late", d_d, 8'h52);
        io1_n = 1'b1;
        wait_neg(5);

        // ---- Decode miss: wrong window, then io1_n high ----
        rd0 = rd_cnt; wr0 = wr_cnt; oe0 = oe_cnt;
        start_cycle(8'h21, 1'b1, 8'h00, 8'h11, 1'b0);
        wait_neg(3);
        check("miss_win_busy", busy, 1'b0);
        wait_neg(20);
        phi2 = 1'b0;
        wait_neg(10);
        start_cycle(8'h02, 1'b1, 8'h00, 8'h11, 1'b1);
        wait_neg(3);
        check("miss_io1_busy", busy, 1'b0);
        wait_neg(20);
        phi2 = 1'b0;
        wait_neg(10);
        #1;
        check("miss_no_rd", rd_cnt - rd0, 0);
        check("miss_no_wr", wr_cnt - wr0, 0);
        check("miss_no_oe", oe_cnt - oe0, 0);
        check("miss_a", a, 4'h3);

        // ---- Reset in the middle of a read ----
        start_cycle(8'h05, 1'b1, 8'h00, 8'h3C, 1'b0);
        wait_neg(6);                                   // k=6, driving
        check("rst_pre_oe", bus_d_oe, 1'b1);
        check("rst_pre_dout", bus_d_out, 8'h3C);
        #2;
        reset = 1'b0;
        #1;                                            // well before next rise
        check_all_zero("rst_async");
        phi2  = 1'b0;
        io1_n = 1'b1;
        wait_neg(3);
        reset = 1'b1;
        wait_neg(5);
        rd0 = rd_cnt;
        start_cycle(8'h09, 1'b1, 8'h00, 8'hC5, 1'b0);
        wait_neg(3);
        check("post_rst_rs", read_strobe, 1'b1);
        check("post_rst_a", a, 4'h9);
        wait_neg(2);
        check("post_rst_oe", bus_d_oe, 1'b1);
        check("post_rst_dout", bus_d_out, 8'hC5);
        wait_neg(10);
        phi2 = 1'b0;
        wait_neg(5);
        #1;
        check("post_rst_count", rd_cnt - rd0, 1);
        check("post_rst_oe_off", bus_d_oe, 1'b0);
        io1_n = 1'b1;
        wait_neg(5);

        // ---- Back-to-back alternating reads and writes ----
        for (int i = 0; i < 100; i++) begin
            logic [3:0] addr;
            logic [7:0] data;
            logic       is_rd;
            addr  = 4'(i % 16);
            data  = 8'(i * 7 + 3);
            is_rd = (i % 2) == 0;
            rd0 = rd_cnt; wr0 = wr_cnt;
            start_cycle({4'h0, addr}, is_rd, data, data, 1'b0);
            if (is_rd) begin
                wait_neg(3);                           // k=3
                check("b2b_rs", read_strobe, 1'b1);
                check("b2b_rd_a", a, addr);
                wait_neg(2);                           // k=5
                check("b2b_dout", bus_d_out, data);
                wait_neg(25);                          // k=30
            end else begin
                wait_neg(5);                           // k=5: disturb the bus
                bus_a = 8'hFF;
                rw    = 1'b1;
                wait_neg(22);                          // k=27
                check("b2b_ws", write_strobe, 1'b1);
                check("b2b_wr_a", a, addr);
                check("b2b_dd", d_d, data);
                wait_neg(3);                           // k=30
            end
            phi2 = 1'b0;
            wait_neg(20);
            #1;
            check("b2b_one_strobe", (rd_cnt - rd0) + (wr_cnt - wr0), 1);
        end
        check("b2b_no_double", dbl_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
